global_predictor: RTL and testbench
===================================

GLOBAL_PREDICTOR -- requirements
Module: global_predictor

Interface
REQ-001 Parameter INDEX_W, default 12, SHALL set the path-history index width; the table holds 2^INDEX_W entries.
REQ-002 Parameter INIT_VAL, default 2'b01, SHALL set the value each 2-bit counter holds after initialisation (weakly not-taken).
REQ-003 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 pred_req  input  1  SHALL request a prediction for pred_index.
REQ-006 pred_index  input  INDEX_W  SHALL carry the path-history value (PHresult of the path-history stage) for the request.
REQ-007 upd_valid  input  1  SHALL request training of entry upd_index.
REQ-008 upd_index  input  INDEX_W  SHALL carry the path-history value captured when the branch was predicted.
REQ-009 upd_taken  input  1  SHALL carry the resolved branch outcome (1 = taken).
REQ-010 ready  output  1  SHALL be high when initialisation is complete and requests are accepted.
REQ-011 pred_valid  output  1  SHALL mark pred_taken and pred_ctr valid for one cycle.
REQ-012 pred_taken  output  1  SHALL be the prediction: MSB of the selected counter.
REQ-013 pred_ctr  output  2  SHALL be the full counter value read for the request.

Function
REQ-014 The block SHALL hold 2^INDEX_W 2-bit saturating counters.
REQ-015 The FSM SHALL have two states, INIT and RUN.
REQ-016 INIT SHALL write INIT_VAL to one entry per cycle, starting at 0 and incrementing an INDEX_W-bit pointer.
REQ-017 INIT SHALL move to RUN on the cycle after the entry at pointer 2^INDEX_W-1 is written, so INIT lasts exactly 2^INDEX_W cycles.
REQ-018 RUN SHALL be held until reset; ready SHALL equal (state == RUN), registered.
REQ-019 In INIT, pred_req and upd_valid SHALL be ignored, with no table change and pred_valid = 0.
REQ-020 In RUN, pred_req at edge N SHALL produce pred_valid = 1 plus the registered pred_taken/pred_ctr after edge N+1; latency is 1 cycle.
REQ-021 pred_valid SHALL be 0 in any cycle not following an accepted request.
REQ-022 pred_taken and pred_ctr SHALL hold their last value while pred_valid = 0.
REQ-023 In RUN, upd_valid SHALL perform read-modify-write of entry upd_index in one cycle.
REQ-024 The update rule SHALL be: taken increments and saturates at 3; not-taken decrements and saturates at 0.
REQ-025 Back-to-back updates to the same index on consecutive cycles SHALL each apply; no lost updates.
REQ-026 If pred_req and upd_valid target the same index in the same cycle, the prediction SHALL return the pre-update value (read-before-write), and the update SHALL still apply.
REQ-027 Prediction and update to different indices in the same cycle SHALL both complete independently.
REQ-028 Index arithmetic SHALL be unsigned INDEX_W bits; the INIT pointer wraps only at the INIT-to-RUN transition.

Reset
REQ-029 Asserting reset SHALL immediately force state = INIT, pointer = 0, ready = 0, pred_valid = 0, pred_taken = 0 and pred_ctr = 2'b00.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart the full INIT sweep after deassertion; no table contents SHALL be relied on from before reset.
REQ-031 Table storage itself SHALL NOT require asynchronous reset; the INIT sweep is the sole initialiser.

Verification
REQ-032 Reset pulse, then idle -> ready = 0 for exactly 4096 cycles, then 1; pred_req during INIT gives pred_valid = 0.
REQ-033 After init, pred_req with pred_index = 12'hABC -> next cycle pred_valid = 1, pred_ctr = 2'b01, pred_taken = 0.
REQ-034 Four consecutive taken updates to index 5, then predict 5 -> pred_ctr = 2'b11 (saturated); five not-taken updates -> pred_ctr = 2'b00.
REQ-035 Same cycle: pred_req at index 7 (ctr = 2'b01) and taken update at index 7 -> pred_ctr = 2'b01; the following predict of 7 returns 2'b10, pred_taken = 1.
REQ-036 Reset asserted at INIT cycle 2000 after prior training of index 5 -> ready drops asynchronously; after the new 4096-cycle sweep, index 5 reads 2'b01.
REQ-037 Random pred/upd traffic against a reference model of 4096 counters -> every pred_valid cycle matches the model, including same-index collisions.

Source files
------------

// File: rtl/global_predictor.sv
// Global branch predictor: a table of 2-bit saturating counters indexed by path history.
// An INIT sweep fills the table after reset. Then one prediction read and one training update run each cycle.
module global_predictor #(
    parameter int         INDEX_W  = 12,
    parameter logic [1:0] INIT_VAL = 2'b01
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pred_req,
    input  logic [INDEX_W-1:0] pred_index,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken,
    output logic               ready,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [1:0]         pred_ctr
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    localparam int                 DEPTH    = 1 << INDEX_W;
    localparam logic [INDEX_W-1:0] PTR_LAST = '1;

    state_t             state_r, state_next_s;
    logic [INDEX_W-1:0] ptr_r, ptr_next_s;
    logic [1:0]         table_r [0:DEPTH-1];
    logic               wr_en_s;
    logic [INDEX_W-1:0] wr_idx_s;
    logic [1:0]         wr_data_s;
    logic               pred_fire_s;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    // State and sweep-pointer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= INIT;
            ptr_r   <= '0;
        end else begin
            state_r <= state_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    // Next-state logic and the single table write port
    always_comb begin
        state_next_s = state_r;
        ptr_next_s   = ptr_r;
        wr_en_s      = 1'b0;
        wr_idx_s     = '0;
        wr_data_s    = 2'b00;
        case (state_r)
            INIT: begin
                wr_en_s    = 1'b1;
                wr_idx_s   = ptr_r;
                wr_data_s  = INIT_VAL;
                // The pointer wraps to zero exactly as the sweep hands over to RUN.
                ptr_next_s = ptr_r + INDEX_W'(1);
                if (ptr_r == PTR_LAST) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = INIT;
                end
            end
            RUN: begin
                wr_en_s   = upd_valid;
                wr_idx_s  = upd_index;
                wr_data_s = sat_update(table_r[upd_index], upd_taken);
            end
            default: begin
                state_next_s = INIT;
                ptr_next_s   = '0;
            end
        endcase
    end

    assign pred_fire_s = (state_r == RUN) && pred_req;

    // Counter storage. It has no reset because the INIT sweep initialises it.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            table_r[wr_idx_s] <= wr_data_s;
        end
    end

    // Registered outputs. A prediction reads the value held before this cycle's update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready      <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_ctr   <= 2'b00;
        end else begin
            ready      <= (state_next_s == RUN);
            pred_valid <= pred_fire_s;
            if (pred_fire_s) begin
                pred_ctr   <= table_r[pred_index];
                pred_taken <= table_r[pred_index][1];
            end
        end
    end

endmodule

// File: tb/tb_global_predictor.sv
// Directed and model-based checks for global_predictor.
// Covers the INIT sweep, the saturating counters, read-before-write collisions and reset during operation.
module tb_global_predictor;

    logic        clock = 1'b0;
    logic        reset;
    logic        pred_req;
    logic [11:0] pred_index;
    logic        upd_valid;
    logic [11:0] upd_index;
    logic        upd_taken;
    logic        ready;
    logic        pred_valid;
    logic        pred_taken;
    logic [1:0]  pred_ctr;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [1:0] model [0:15];

    global_predictor #(.INDEX_W(12), .INIT_VAL(2'b01)) dut (
        .clock      (clock),
        .reset      (reset),
        .pred_req   (pred_req),
        .pred_index (pred_index),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .ready      (ready),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ctr   (pred_ctr)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_init(input string tag, input bit noisy);
        int n;
        bit saw;
        n = 0;
        saw = 1'b0;
        while (!ready && n < 5000) begin
            if (noisy) begin
                pred_req   = 1'b1;
                pred_index = 12'(n);
                upd_valid  = 1'b1;
                upd_index  = 12'd9;
                upd_taken  = 1'b1;
            end
            step();
            n++;
            if (pred_valid) saw = 1'b1;
        end
        pred_req  = 1'b0;
        upd_valid = 1'b0;
        check({tag, "_len"}, n, 4096);
        if (noisy) check({tag, "_no_pv"}, 32'(saw), 32'd0);
    endtask

    task automatic predict(input string tag, input logic [11:0] idx, input logic [1:0] exp);
        pred_req   = 1'b1;
        pred_index = idx;
        step();
        pred_req   = 1'b0;
        check({tag, "_pv"}, 32'(pred_valid), 32'd1);
        check({tag, "_ctr"}, 32'(pred_ctr), 32'(exp));
        check({tag, "_taken"}, 32'(pred_taken), 32'(exp[1]));
    endtask

    task automatic train(input logic [11:0] idx, input logic taken, input int times);
        upd_valid = 1'b1;
        upd_index = idx;
        upd_taken = taken;
        repeat (times) step();
        upd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        pred_req = 1'b0; pred_index = 12'd0;
        upd_valid = 1'b0; upd_index = 12'd0; upd_taken = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_pv", 32'(pred_valid), 32'd0);
        check("rst_ctr", 32'(pred_ctr), 32'd0);
        reset = 1'b0;
        wait_init("init1", 1'b1);

        predict("abc", 12'hABC, 2'b01);
        predict("ign9", 12'd9, 2'b01);

        train(12'd5, 1'b1, 4);
        predict("sat_hi", 12'd5, 2'b11);
        step();
        check("hold_pv", 32'(pred_valid), 32'd0);
        check("hold_ctr", 32'(pred_ctr), 32'd3);
        train(12'd5, 1'b0, 5);
        predict("sat_lo", 12'd5, 2'b00);

        train(12'd6, 1'b1, 2);
        predict("i6_a", 12'd6, 2'b11);
        train(12'd6, 1'b0, 1);
        predict("i6_b", 12'd6, 2'b10);

        // Collision: prediction of 7 must see the pre-update counter.
        pred_req = 1'b1; pred_index = 12'd7;
        upd_valid = 1'b1; upd_index = 12'd7; upd_taken = 1'b1;
        step();
        pred_req = 1'b0; upd_valid = 1'b0;
        check("coll_ctr", 32'(pred_ctr), 32'd1);
        predict("coll_after", 12'd7, 2'b10);

        pred_req = 1'b1; pred_index = 12'd5;
        upd_valid = 1'b1; upd_index = 12'd8; upd_taken = 1'b1;
        step();
        pred_req = 1'b0; upd_valid = 1'b0;
        check("indep_ctr", 32'(pred_ctr), 32'd0);
        predict("indep_8", 12'd8, 2'b10);

        // Retrain 5 and then reset mid-RUN. The outputs must clear without a clock edge.
        train(12'd5, 1'b1, 3);
        #2;
        reset = 1'b1;
        #1;
        check("async_ready", 32'(ready), 32'd0);
        check("async_ctr", 32'(pred_ctr), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2000) step();
        check("mid_init_ready", 32'(ready), 32'd0);
        reset = 1'b1;
        #1;
        check("mid_init_rst", 32'(ready), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_init("init2", 1'b0);
        predict("reinit5", 12'd5, 2'b01);
        predict("reinit7", 12'd7, 2'b01);

        // Random traffic on a small index window to force collisions.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        wait_init("init3", 1'b0);
        for (int i = 0; i < 16; i++) model[i] = 2'b01;
        for (int k = 0; k < 300; k++) begin
            logic [1:0] exp_ctr;
            logic       req;
            req        = 1'($urandom_range(0, 1));
            pred_req   = req;
            pred_index = 12'($urandom_range(0, 15));
            upd_valid  = 1'($urandom_range(0, 1));
            upd_index  = 12'($urandom_range(0, 15));
            upd_taken  = 1'($urandom_range(0, 1));
            exp_ctr = model[pred_index[3:0]];
            if (upd_valid) begin
                if (upd_taken) begin
                    if (model[upd_index[3:0]] != 2'b11) model[upd_index[3:0]] = model[upd_index[3:0]] + 2'b01;
                end else begin
                    if (model[upd_index[3:0]] != 2'b00) model[upd_index[3:0]] = model[upd_index[3:0]] - 2'b01;
                end
            end
            step();
            check("rnd_pv", 32'(pred_valid), 32'(req));
            if (req) check("rnd_ctr", 32'(pred_ctr), 32'(exp_ctr));
        end
        pred_req = 1'b0;
        upd_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
